// File: rtl/ctl_pkg.sv
// Shared EX-stage control definitions: funct codes, ALUOp encodings and the
// divu sequencer state type. Also used by the ALU control unit.
package ctl_pkg;

   // R-type funct codes decoded in EX
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_DIVU = 6'b011011;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;

   // ALUOp encodings from the main decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   // divu sequencer states
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DONE,
      DONE_Z
   } divu_state_e;

endpackage : ctl_pkg

// File: rtl/divu_seq_ctl_if.sv
// EX-stage signals between the pipeline/divider datapath and the divu
// sequencer. The pipeline side is the master; the sequencer is the slave.
interface divu_seq_ctl_if #(
   parameter int CNT_W = 6
);

   // pipeline / datapath -> sequencer
   logic             ex_valid;
   logic [1:0]       ex_alu_op;
   logic [5:0]       ex_funct;
   logic             flush;
   logic             divisor_zero;

   // sequencer -> divider, HI/LO file, hazard network
   logic             div_load;
   logic             div_step;
   logic [CNT_W-1:0] step_cnt;
   logic             hilo_we;
   logic             busy;
   logic             stall;
   logic             div_by_zero;

   modport master (
      output ex_valid, ex_alu_op, ex_funct, flush, divisor_zero,
      input  div_load, div_step, step_cnt, hilo_we, busy, stall, div_by_zero
   );

   modport slave (
      input  ex_valid, ex_alu_op, ex_funct, flush, divisor_zero,
      output div_load, div_step, step_cnt, hilo_we, busy, stall, div_by_zero
   );

endinterface : divu_seq_ctl_if

// File: rtl/divu_seq_ctl.sv
// Multi-cycle sequencer for the unsigned divider. Holds the pipeline while a
// divu runs, strobes the divider through LOAD and XLEN steps, and commits the
// result to HI/LO with a single write pulse. Supports flush and divide-by-zero.
module divu_seq_ctl #(
   parameter int          XLEN     = 32,
   parameter int          CNT_W    = 6,
   parameter logic [5:0]  F_DIVU   = 6'b011011,
   parameter logic [1:0]  OP_RTYPE = 2'b10
) (
   input  logic           clk,
   input  logic           rst,
   divu_seq_ctl_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

   ctl_pkg::divu_state_e state;
   logic [CNT_W-1:0]     step_q;
   logic                 load_q;
   logic                 step_en_q;
   logic                 hilo_q;
   logic                 busy_q;
   logic                 dbz_q;
   logic                 start;

   // A divu is accepted only from IDLE, so the instruction still sitting in
   // EX during DONE/DONE_Z can never re-trigger the sequence.
   assign start = bus.ex_valid
                & (bus.ex_alu_op == OP_RTYPE)
                & (bus.ex_funct == F_DIVU)
                & ~bus.flush
                & (state == ctl_pkg::IDLE);

   // Sequencer FSM with embedded step counter; all strobes are registered so
   // they are decoded for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ctl_pkg::IDLE;
         step_q    <= '0;
         load_q    <= 1'b0;
         step_en_q <= 1'b0;
         hilo_q    <= 1'b0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; the defaults below are overridden
         // by later assignments in the same block, giving one-cycle strobes.
         load_q    <= 1'b0;
         step_en_q <= 1'b0;
         hilo_q    <= 1'b0;
         case (state)
            ctl_pkg::IDLE: begin
               if (start) begin
                  state  <= ctl_pkg::LOAD;
                  load_q <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            ctl_pkg::LOAD: begin
               step_q <= '0;
               if (bus.flush) begin
                  state  <= ctl_pkg::IDLE;
                  busy_q <= 1'b0;
               end else if (bus.divisor_zero) begin
                  state  <= ctl_pkg::DONE_Z;
                  busy_q <= 1'b0;
                  dbz_q  <= 1'b1;
               end else begin
                  state     <= ctl_pkg::RUN;
                  step_en_q <= 1'b1;
                  dbz_q     <= 1'b0;
               end
            end
            ctl_pkg::RUN: begin
               if (bus.flush) begin
                  // killed divide: abandon without touching HI/LO
                  state  <= ctl_pkg::IDLE;
                  step_q <= '0;
                  busy_q <= 1'b0;
               end else if (step_q == LAST_STEP) begin
                  state  <= ctl_pkg::DONE;
                  step_q <= '0;
                  busy_q <= 1'b0;
                  hilo_q <= 1'b1;
               end else begin
                  step_q    <= step_q + 1'b1;
                  step_en_q <= 1'b1;
               end
            end
            // DONE ignores flush: the result has already been computed and commits
            ctl_pkg::DONE:   state <= ctl_pkg::IDLE;
            ctl_pkg::DONE_Z: state <= ctl_pkg::IDLE;
            default:         state <= ctl_pkg::IDLE;
         endcase
      end
   end

   // Output drive; stall covers the first EX cycle combinationally so the
   // divu is frozen in EX before LOAD is even entered.
   assign bus.div_load    = load_q;
   assign bus.div_step    = step_en_q;
   assign bus.step_cnt    = step_q;
   assign bus.hilo_we     = hilo_q;
   assign bus.busy        = busy_q;
   assign bus.stall       = busy_q | start;
   assign bus.div_by_zero = dbz_q;

endmodule : divu_seq_ctl
